// File: rtl/onehot_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// onehot_rr_arbiter_if
// Handshake bundle between a set of requesters and the round-robin arbiter.
//   en          : arbitration enable (requester side -> arbiter)
//   req[N]      : level-sensitive request lines (requester side -> arbiter)
//   gnt_ready   : downstream accepts the current grant (-> arbiter)
//   gnt_valid   : a grant is held on gnt_onehot/gnt_idx (arbiter ->)
//   gnt_onehot  : registered one-hot grant, zero when gnt_valid=0
//   gnt_idx     : binary index of the granted bit, zero when gnt_valid=0
// Modports: slave = arbiter side, master = requester/downstream side.
// ---------------------------------------------------------------------------
interface onehot_rr_arbiter_if #(
  parameter int N = 16
);
  localparam int IDX_W = $clog2(N);

  logic             en;
  logic [N-1:0]     req;
  logic             gnt_ready;
  logic             gnt_valid;
  logic [N-1:0]     gnt_onehot;
  logic [IDX_W-1:0] gnt_idx;

  modport slave (
    input  en,
    input  req,
    input  gnt_ready,
    output gnt_valid,
    output gnt_onehot,
    output gnt_idx
  );

  modport master (
    output en,
    output req,
    output gnt_ready,
    input  gnt_valid,
    input  gnt_onehot,
    input  gnt_idx
  );
endinterface

// File: rtl/onehot_rr_arbiter.sv
// ---------------------------------------------------------------------------
// onehot_rr_arbiter
// Round-robin arbiter producing a registered one-hot grant plus its binary
// index behind a valid/ready handshake. A rotating priority pointer advances
// past every accepted grant so each requester gets a fair turn.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : onehot_rr_arbiter_if.slave (en, req, gnt_ready, gnt_valid,
//          gnt_onehot, gnt_idx)
// ---------------------------------------------------------------------------
module onehot_rr_arbiter #(
  parameter int N = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  onehot_rr_arbiter_if.slave    bus
);
  localparam int IDX_W = $clog2(N);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic [IDX_W-1:0] r_gnt_idx;
  logic [IDX_W-1:0] w_gnt_idx_nxt;
  logic [N-1:0]     r_gnt_onehot;
  logic [N-1:0]     w_gnt_onehot_nxt;
  logic [IDX_W-1:0] w_start;
  logic [IDX_W-1:0] w_win;
  logic [N-1:0]     w_win_onehot;
  logic             w_found;
  logic             w_load;

  // Circular first-set search starting at 'start'. The index arithmetic
  // wraps naturally in IDX_W bits, which gives the s..N-1,0..s-1 order.
  function automatic logic [IDX_W:0] rr_search(
    input logic [N-1:0]     vec,
    input logic [IDX_W-1:0] start
  );
    logic             found;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] cand;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < N; i++) begin
      cand = start + IDX_W'(i);
      if (!found && vec[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    return {found, win};
  endfunction

  // While a grant is held the search for a back-to-back grant starts just
  // past the current winner, so the winner itself is lowest priority. In
  // IDLE the stored pointer already holds that position.
  always_comb begin
    w_start = (r_state == HOLD) ? (r_gnt_idx + IDX_W'(1)) : r_ptr;
  end

  always_comb begin
    {w_found, w_win} = rr_search(bus.req, w_start);
    w_win_onehot     = {{(N-1){1'b0}}, 1'b1} << w_win;
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt      = r_state;
    w_ptr_nxt        = r_ptr;
    w_gnt_idx_nxt    = r_gnt_idx;
    w_gnt_onehot_nxt = r_gnt_onehot;
    w_load           = bus.en && w_found;

    case (r_state)
      IDLE: begin
        if (w_load) begin
          w_state_nxt      = HOLD;
          w_gnt_idx_nxt    = w_win;
          w_gnt_onehot_nxt = w_win_onehot;
        end
      end
      HOLD: begin
        // Grant is sticky until accepted, regardless of req/en.
        if (bus.gnt_ready) begin
          w_ptr_nxt = r_gnt_idx + IDX_W'(1);
          if (w_load) begin
            w_gnt_idx_nxt    = w_win;
            w_gnt_onehot_nxt = w_win_onehot;
          end else begin
            w_state_nxt      = IDLE;
            w_gnt_idx_nxt    = '0;
            w_gnt_onehot_nxt = '0;
          end
        end
      end
      default: begin
        w_state_nxt      = IDLE;
        w_gnt_idx_nxt    = '0;
        w_gnt_onehot_nxt = '0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_gnt_idx    <= '0;
      r_gnt_onehot <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_gnt_idx    <= w_gnt_idx_nxt;
      r_gnt_onehot <= w_gnt_onehot_nxt;
    end
  end

  assign bus.gnt_valid  = (r_state == HOLD);
  assign bus.gnt_onehot = r_gnt_onehot;
  assign bus.gnt_idx    = r_gnt_idx;

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_onehot_rr_arbiter
// Directed bench for onehot_rr_arbiter (N=16). Each step drives the inputs
// for one cycle and queues the outputs expected after the next rising edge;
// the entry is popped and compared 1 time unit after that edge.
// ---------------------------------------------------------------------------
module tb_onehot_rr_arbiter;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  onehot_rr_arbiter_if #(.N(N)) bus ();

  onehot_rr_arbiter #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        vld;
    logic [15:0] oh;
    logic [3:0]  idx;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [3:0] oh2idx(input logic [15:0] oh);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) r = 4'(i);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ptr(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, dut.r_ptr}, {28'd0, exp});
  endtask

  // One cycle: drive inputs, queue expected outputs, clock, pop and compare.
  task automatic step(input logic r, input logic e, input logic [15:0] rq,
                      input logic rdy, input logic ev, input logic [15:0] eoh,
                      input string tag);
    exp_t x;
    rst           = r;
    bus.en        = e;
    bus.req       = rq;
    bus.gnt_ready = rdy;
    x.vld = ev;
    x.oh  = eoh;
    x.idx = oh2idx(eoh);
    x.tag = tag;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      x = sb.pop_front();
      chk({x.tag, "_vld"}, {31'd0, bus.gnt_valid}, {31'd0, x.vld});
      chk({x.tag, "_oh"},  {16'd0, bus.gnt_onehot}, {16'd0, x.oh});
      chk({x.tag, "_idx"}, {28'd0, bus.gnt_idx}, {28'd0, x.idx});
      chk({x.tag, "_inv"},
          {31'd0, (bus.gnt_valid ? (bus.gnt_onehot == (16'd1 << bus.gnt_idx))
                                 : (bus.gnt_onehot == 16'd0 && bus.gnt_idx == 4'd0))},
          32'd1);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; bus.en = 1'b0; bus.req = '0; bus.gnt_ready = 1'b0;

    // Reset with all requests asserted: outputs stay zero
    step(1, 1, 16'hFFFF, 0, 0, 16'h0000, "rst0");
    step(1, 1, 16'hFFFF, 0, 0, 16'h0000, "rst1");
    chk_ptr("rst_ptr", 4'd0);
    step(0, 0, 16'hFFFF, 0, 0, 16'h0000, "post_rst");
    step(0, 1, 16'hFFFF, 0, 1, 16'h0001, "first");
    // Accept with en low -> idle, ptr=1
    step(0, 0, 16'hFFFF, 1, 0, 16'h0000, "acc_first");
    chk_ptr("ptr_after_first", 4'd1);

    // Rotation, back-to-back with ready high
    step(0, 1, 16'h0124, 1, 1, 16'h0004, "rot0");
    step(0, 1, 16'h0124, 1, 1, 16'h0020, "rot1");
    step(0, 1, 16'h0124, 1, 1, 16'h0100, "rot2");
    step(0, 1, 16'h0124, 1, 1, 16'h0004, "rot3");
    step(0, 0, 16'h0000, 0, 1, 16'h0004, "rot_hold");
    step(0, 0, 16'h0000, 1, 0, 16'h0000, "rot_end");
    chk_ptr("ptr_after_rot", 4'd3);
    // Ready while idle is ignored
    step(0, 0, 16'h0000, 1, 0, 16'h0000, "idle_rdy");
    chk_ptr("ptr_idle_rdy", 4'd3);

    // Stall / stickiness
    step(0, 1, 16'h0010, 0, 1, 16'h0010, "stall_gnt");
    for (int i = 0; i < 5; i++)
      step(0, 0, 16'h0000, 0, 1, 16'h0010, "stall_hold");
    step(0, 0, 16'h0000, 1, 0, 16'h0000, "stall_acc");
    chk_ptr("ptr_after_stall", 4'd5);

    // Wrap-around
    step(0, 1, 16'h4000, 0, 1, 16'h4000, "wrap_g14");
    step(0, 1, 16'h8001, 1, 1, 16'h8000, "wrap_g15");
    chk_ptr("ptr15", 4'd15);
    step(0, 1, 16'h8001, 1, 1, 16'h0001, "wrap_g0");
    chk_ptr("ptr_wrapped", 4'd0);
    step(0, 1, 16'h8001, 1, 1, 16'h8000, "wrap_g15b");
    step(0, 0, 16'h0000, 1, 0, 16'h0000, "wrap_end");
    chk_ptr("ptr_after_wrap", 4'd0);

    // Sole requester re-granted every cycle
    step(0, 1, 16'h0040, 1, 1, 16'h0040, "sole0");
    step(0, 1, 16'h0040, 1, 1, 16'h0040, "sole1");
    step(0, 1, 16'h0040, 1, 1, 16'h0040, "sole2");
    step(0, 1, 16'h0040, 1, 1, 16'h0040, "sole3");
    step(0, 0, 16'h0000, 1, 0, 16'h0000, "sole_end");
    chk_ptr("ptr_after_sole", 4'd7);

    // Reset mid-grant
    step(0, 1, 16'h0200, 0, 1, 16'h0200, "mid_gnt");
    step(0, 1, 16'h0200, 0, 1, 16'h0200, "mid_hold");
    step(1, 1, 16'h0201, 0, 0, 16'h0000, "mid_rst");
    chk_ptr("ptr_mid_rst", 4'd0);
    step(0, 1, 16'h0201, 0, 1, 16'h0001, "post_mid");
    step(0, 1, 16'h0201, 1, 1, 16'h0200, "post_mid_b2b");
    step(0, 0, 16'h0000, 1, 0, 16'h0000, "final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
